// File: rtl/prco_prog_loader.sv
// Program loader: receives framed program images over a byte link, writes 16-bit
// words into prco_lmem and holds prco_core in reset until a frame checks out.
module prco_prog_loader #(
    parameter logic [7:0]  MAGIC         = 8'hA5,
    parameter logic [15:0] BASE_ADDR     = 16'h0,
    parameter int unsigned MAX_WORDS     = 1024,
    parameter bit          HOLD_ON_RESET = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte_data,
    output logic        q_byte_ready,
    output logic        q_mem_we,
    output logic [15:0] q_mem_addr,
    output logic [15:0] q_mem_din,
    output logic        q_core_reset,
    output logic        q_busy,
    output logic        q_done,
    output logic        q_err
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   count_q, count_d;
    logic [WORD_W-1:0]   index_q, index_d;
    logic [BYTE_W-1:0]   csum_q, csum_d;
    logic [BYTE_W-1:0]   hi_q, hi_d;
    logic                ready_q, ready_d;
    logic                we_q, we_d;
    logic [WORD_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   din_q, din_d;
    logic                core_reset_q, core_reset_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                byte_acc;
    logic [WORD_W-1:0]   len_word;
    logic [WORD_W-1:0]   index_inc;

    assign byte_acc  = i_byte_valid && ready_q;
    assign len_word  = {count_q[WORD_W-1:BYTE_W], i_byte_data};
    assign index_inc = index_q + WORD_W'(1);

    // State and registered outputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            index_q      <= '0;
            csum_q       <= '0;
            hi_q         <= '0;
            ready_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= BASE_ADDR;
            din_q        <= '0;
            core_reset_q <= HOLD_ON_RESET;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            index_q      <= index_d;
            csum_q       <= csum_d;
            hi_q         <= hi_d;
            ready_q      <= ready_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            core_reset_q <= core_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Frame parser: next state and next output values
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        index_d      = index_q;
        csum_d       = csum_q;
        hi_d         = hi_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        din_d        = din_q;
        core_reset_d = core_reset_q;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = err_q;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (byte_acc && (i_byte_data == MAGIC)) begin
                    state_d      = S_LEN_HI;
                    core_reset_d = 1'b1;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    err_d        = 1'b0;
                    csum_d       = '0;
                    index_d      = '0;
                end
            end
            S_LEN_HI: begin
                if (byte_acc) begin
                    count_d = {i_byte_data, count_q[BYTE_W-1:0]};
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (byte_acc) begin
                    count_d = len_word;
                    if (len_word == '0) begin
                        state_d = S_CSUM;
                    end else if (32'(len_word) > 32'(MAX_WORDS)) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (byte_acc) begin
                    hi_d    = i_byte_data;
                    csum_d  = csum_q ^ i_byte_data;
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                // The write strobe is registered, so it is raised on entry to WRITE
                if (byte_acc) begin
                    csum_d  = csum_q ^ i_byte_data;
                    state_d = S_WRITE;
                    we_d    = 1'b1;
                    addr_d  = BASE_ADDR + index_q;
                    din_d   = {hi_q, i_byte_data};
                end
            end
            S_WRITE: begin
                index_d = index_inc;
                state_d = (index_inc == count_q) ? S_CSUM : S_DATA_HI;
            end
            S_CSUM: begin
                if (byte_acc) begin
                    busy_d = 1'b0;
                    if (i_byte_data == csum_q) begin
                        state_d      = S_DONE;
                        done_d       = 1'b1;
                        core_reset_d = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Ready drops only for the write slot
    assign ready_d = (state_d != S_WRITE);

    assign q_byte_ready = ready_q;
    assign q_mem_we     = we_q;
    assign q_mem_addr   = addr_q;
    assign q_mem_din    = din_q;
    assign q_core_reset = core_reset_q;
    assign q_busy       = busy_q;
    assign q_done       = done_q;
    assign q_err        = err_q;

endmodule

// File: tb/tb_prco_prog_loader.sv
// Bench for prco_prog_loader: directed frames plus randomized frames checked
// against a frame-level model of expected writes, status and core reset.
module tb_prco_prog_loader;

    localparam logic [7:0]  MAGIC = 8'hA5;
    localparam logic [15:0] BASE  = 16'h0;
    localparam int          MAXW  = 1024;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_byte_valid = 1'b0;
    logic [7:0]  i_byte_data = 8'h00;
    logic        q_byte_ready;
    logic        q_mem_we;
    logic [15:0] q_mem_addr;
    logic [15:0] q_mem_din;
    logic        q_core_reset;
    logic        q_busy;
    logic        q_done;
    logic        q_err;

    int          vectors = 0;
    int          miscompares = 0;
    int          wr_count = 0;
    logic [15:0] wq[$];
    logic        exp_done = 1'b0;
    logic        exp_err = 1'b0;
    logic        exp_cr = 1'b1;

    prco_prog_loader dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_byte_valid (i_byte_valid),
        .i_byte_data  (i_byte_data),
        .q_byte_ready (q_byte_ready),
        .q_mem_we     (q_mem_we),
        .q_mem_addr   (q_mem_addr),
        .q_mem_din    (q_mem_din),
        .q_core_reset (q_core_reset),
        .q_busy       (q_busy),
        .q_done       (q_done),
        .q_err        (q_err)
    );

    always #5 i_clk = ~i_clk;

    // Count every write strobe cycle to catch extra or missing writes
    always @(negedge i_clk) begin
        if (!i_reset && q_mem_we === 1'b1) wr_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output int waited);
        i_byte_valid = 1'b1;
        i_byte_data  = b;
        waited = 0;
        while (q_byte_ready !== 1'b1 && waited < 64) begin
            @(negedge i_clk);
            waited++;
        end
        if (waited >= 64) check("accept_timeout", 32'(0), 32'(1));
        @(negedge i_clk);
    endtask

    task automatic gap(input bit en);
        if (en) begin
            i_byte_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge i_clk);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_done"}, 32'(q_done), 32'(exp_done));
        check({tag, "_err"}, 32'(q_err), 32'(exp_err));
        check({tag, "_busy"}, 32'(q_busy), 32'(0));
        check({tag, "_corerst"}, 32'(q_core_reset), 32'(exp_cr));
    endtask

    task automatic send_junk(input int n, input string tag);
        logic [7:0] b;
        int w;
        for (int k = 0; k < n; k++) begin
            b = 8'($urandom);
            if (b == MAGIC) b = 8'h00;
            send_byte(b, w);
        end
        i_byte_valid = 1'b0;
        check_status(tag);
    endtask

    // Sends one frame built from wq and checks each write and the final status
    task automatic run_frame(input logic [15:0] len, input logic [7:0] csum_delta,
                             input bit gaps, input string tag);
        int w;
        int wr0;
        logic [7:0] x;
        logic good;
        wr0 = wr_count;
        x = 8'h00;
        gap(gaps);
        send_byte(MAGIC, w);
        check({tag, "_start_busy"}, 32'(q_busy), 32'(1));
        check({tag, "_start_corerst"}, 32'(q_core_reset), 32'(1));
        check({tag, "_start_clr"}, 32'({q_done, q_err}), 32'(0));
        gap(gaps);
        send_byte(len[15:8], w);
        gap(gaps);
        send_byte(len[7:0], w);
        if (int'(len) > MAXW) begin
            i_byte_valid = 1'b0;
            exp_done = 1'b0;
            exp_err  = 1'b1;
            exp_cr   = 1'b1;
            check_status({tag, "_oversize"});
            @(negedge i_clk);
            check({tag, "_oversize_writes"}, 32'(wr_count - wr0), 32'(0));
            return;
        end
        for (int i = 0; i < int'(len); i++) begin
            x = x ^ wq[i][15:8] ^ wq[i][7:0];
            gap(gaps);
            send_byte(wq[i][15:8], w);
            if (i > 0 && !gaps) check({tag, "_ready_gap"}, 32'(w), 32'(1));
            gap(gaps);
            send_byte(wq[i][7:0], w);
            check({tag, "_we"}, 32'(q_mem_we), 32'(1));
            check({tag, "_addr"}, 32'(q_mem_addr), 32'(BASE + 16'(i)));
            check({tag, "_din"}, 32'(q_mem_din), 32'(wq[i]));
            check({tag, "_ready_wr"}, 32'(q_byte_ready), 32'(0));
            check({tag, "_busy_wr"}, 32'({q_busy, q_core_reset}), 32'(3));
        end
        gap(gaps);
        send_byte(x ^ csum_delta, w);
        if (len != 16'h0 && !gaps) check({tag, "_ready_gap_cs"}, 32'(w), 32'(1));
        i_byte_valid = 1'b0;
        good = (csum_delta == 8'h00);
        exp_done = good;
        exp_err  = !good;
        exp_cr   = !good;
        check_status({tag, "_end"});
        check({tag, "_writes"}, 32'(wr_count - wr0), 32'(len));
    endtask

    task automatic fill_random(input int n);
        wq.delete();
        for (int i = 0; i < n; i++)
            wq.push_back(($urandom_range(0, 3) == 0) ? 16'hA5A5 : 16'($urandom));
    endtask

    initial begin
        int w;
        logic [15:0] len;
        logic [7:0] delta;

        // Reset state
        repeat (2) @(negedge i_clk);
        check("rst_ready", 32'(q_byte_ready), 32'(0));
        check("rst_we", 32'(q_mem_we), 32'(0));
        check("rst_addr", 32'(q_mem_addr), 32'(BASE));
        check("rst_din", 32'(q_mem_din), 32'(0));
        check_status("rst");
        i_reset = 1'b0;
        @(negedge i_clk);
        check("idle_ready", 32'(q_byte_ready), 32'(1));

        // T3: junk ignored, then zero-length frame
        send_junk(3, "t3_junk");
        wq.delete();
        run_frame(16'h0000, 8'h00, 1'b0, "t3");

        // T1: good frame
        wq = '{16'h1234, 16'hABCD};
        run_frame(16'h0002, 8'h00, 1'b0, "t1");
        send_junk(2, "t1_junk");

        // T2: bad checksum 0x41
        run_frame(16'h0002, 8'h01, 1'b0, "t2");

        // T4: oversize, then recover with T1
        run_frame(16'h0401, 8'h00, 1'b0, "t4");
        wq = '{16'h1234, 16'hABCD};
        run_frame(16'h0002, 8'h00, 1'b0, "t4_t1");

        // T5: back-to-back bytes with valid held high
        fill_random(8);
        run_frame(16'h0008, 8'h00, 1'b0, "t5");

        // T6: reset mid-frame
        send_byte(MAGIC, w);
        send_byte(8'h00, w);
        send_byte(8'h03, w);
        send_byte(8'h12, w);
        i_byte_valid = 1'b0;
        i_reset = 1'b1;
        #1;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_cr   = 1'b1;
        check("t6_ready", 32'(q_byte_ready), 32'(0));
        check("t6_we", 32'(q_mem_we), 32'(0));
        check("t6_addr", 32'(q_mem_addr), 32'(BASE));
        check("t6_din", 32'(q_mem_din), 32'(0));
        check_status("t6_rst");
        @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        wq = '{16'h1234, 16'hABCD};
        run_frame(16'h0002, 8'h00, 1'b0, "t6_t1");

        // Largest accepted frame
        fill_random(MAXW);
        run_frame(16'(MAXW), 8'h00, 1'b0, "max");

        // Randomized frames
        for (int f = 0; f < 16; f++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) len = 16'h0;
            else if (r == 1) len = 16'($urandom_range(MAXW + 1, 65535));
            else len = 16'($urandom_range(1, 10));
            fill_random((int'(len) > MAXW) ? 0 : int'(len));
            delta = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            send_junk($urandom_range(0, 3), "rnd_junk");
            run_frame(len, delta, 1'($urandom_range(0, 1)), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
